gba_dma_bus_arbiter: RTL

GBA_DMA_BUS_ARBITER -- requirements
Module: gba_dma_bus_arbiter

---
 rtl/gba_dma_bus_arbiter_if.sv | 37 +++
 rtl/gba_dma_bus_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/gba_dma_bus_arbiter_if.sv
// DMA arbiter bus bundle: channel requests and completion pulses in, grant and status out.
// master drives requests and CPU/memory status; slave is the arbiter.
interface gba_dma_bus_arbiter_if;
    logic [3:0] dma_req;
    logic       dma_unit_done;
    logic       dma_done;
    logic       cpu_preemptable;
    logic       mem_wait;
    logic [3:0] dma_grant;
    logic [1:0] grant_id;
    logic       dma_active;
    logic [7:0] preempt_cnt;

    modport master (
        output dma_req,
        output dma_unit_done,
        output dma_done,
        output cpu_preemptable,
        output mem_wait,
        input  dma_grant,
        input  grant_id,
        input  dma_active,
        input  preempt_cnt
    );

    modport slave (
        input  dma_req,
        input  dma_unit_done,
        input  dma_done,
        input  cpu_preemptable,
        input  mem_wait,
        output dma_grant,
        output grant_id,
        output dma_active,
        output preempt_cnt
    );
endinterface

// File: rtl/gba_dma_bus_arbiter.sv
// Four-channel fixed-priority DMA bus arbiter (bit 0 highest) with a one-cycle CPU turnaround.
// Define GBA_DMA_ARB_PREEMPT_EN to let a higher-priority channel take the bus at a unit boundary.
module gba_dma_bus_arbiter (
    input logic                        clk,
    input logic                        rst_b,
    gba_dma_bus_arbiter_if.slave       dma_io
);

    typedef enum logic [1:0] {StIdle, StArm, StGrant, StTurn} state_e;

    state_e     state_q;
    logic [3:0] grant_q;
    logic [1:0] grant_id_q;
    logic       active_q;

    logic [3:0] pick_onehot;
    logic [1:0] pick_id;
    logic       any_req;
    logic       granted_req;

    assign any_req     = |dma_io.dma_req;
    assign granted_req = |(dma_io.dma_req & grant_q);

    always_comb begin
        pick_onehot = 4'b0000;
        pick_id     = 2'd0;
        casez (dma_io.dma_req)
            4'b???1: begin pick_onehot = 4'b0001; pick_id = 2'd0; end
            4'b??10: begin pick_onehot = 4'b0010; pick_id = 2'd1; end
            4'b?100: begin pick_onehot = 4'b0100; pick_id = 2'd2; end
            4'b1000: begin pick_onehot = 4'b1000; pick_id = 2'd3; end
            default: begin pick_onehot = 4'b0000; pick_id = 2'd0; end
        endcase
    end

`ifdef GBA_DMA_ARB_PREEMPT_EN
    logic [7:0] preempt_cnt_q;
    logic       higher_pend;
    logic       preempt_hit;

    // grant_q is one-hot, so grant_q - 1 masks exactly the higher-priority channels.
    assign higher_pend = |(dma_io.dma_req & (grant_q - 4'd1));
    assign preempt_hit = dma_io.dma_unit_done & ~dma_io.dma_done & higher_pend;
    assign dma_io.preempt_cnt = preempt_cnt_q;
`else
    logic unused_unit_done;
    assign unused_unit_done   = dma_io.dma_unit_done;
    assign dma_io.preempt_cnt = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            active_q   <= 1'b0;
`ifdef GBA_DMA_ARB_PREEMPT_EN
            preempt_cnt_q <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (!any_req) begin
                        state_q <= StIdle;
                    end else if (dma_io.cpu_preemptable && !dma_io.mem_wait) begin
                        state_q    <= StGrant;
                        grant_q    <= pick_onehot;
                        grant_id_q <= pick_id;
                        active_q   <= 1'b1;
                    end
                end
                StGrant: begin
                    // A stalled access freezes the grant; done, abort and preemption all wait.
                    if (!dma_io.mem_wait) begin
                        if (dma_io.dma_done || !granted_req) begin
                            state_q    <= StTurn;
                            grant_q    <= 4'b0000;
                            grant_id_q <= 2'd0;
                            active_q   <= 1'b0;
                        end
`ifdef GBA_DMA_ARB_PREEMPT_EN
                        else if (preempt_hit) begin
                            grant_q    <= pick_onehot;
                            grant_id_q <= pick_id;
                            if (preempt_cnt_q != 8'hFF) begin
                                preempt_cnt_q <= preempt_cnt_q + 8'd1;
                            end
                        end
`endif
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    grant_q    <= 4'b0000;
                    grant_id_q <= 2'd0;
                    active_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dma_io.dma_grant  = grant_q;
    assign dma_io.grant_id   = grant_id_q;
    assign dma_io.dma_active = active_q;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            assert ((grant_q & (grant_q - 4'd1)) == 4'b0000)
                else $error("dma_grant not one-hot: %b", grant_q);
            assert ((state_q == StGrant) || (grant_q == 4'b0000))
                else $error("dma_grant set outside GRANT: %b", grant_q);
        end
    end

endmodule
